// File: rtl/l17_pkg.sv
// Shared types for the L17 loop scheduler: FSM states, loop modes and the z-limit lookup.
package l17_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] MODE_0 = 3'd0;
    localparam logic [2:0] MODE_1 = 3'd1;
    localparam logic [2:0] MODE_2 = 3'd2;
    localparam logic [2:0] MODE_3 = 3'd3;
    localparam logic [2:0] MODE_4 = 3'd4;

    // Out-of-range modes fold onto mode 0.
    function automatic logic [2:0] mode_norm(input logic [2:0] m);
        return (m > MODE_4) ? MODE_0 : m;
    endfunction

    // Returns ZLIM-1 so the limit fits the 4-bit z counter.
    function automatic logic [3:0] zlim_max(input logic [2:0] m);
        case (m)
            MODE_1:         return 4'd7;
            MODE_2:         return 4'd3;
            MODE_3, MODE_4: return 4'd7;
            default:        return 4'd15;
        endcase
    endfunction

endpackage

// File: rtl/l17_wrap_cnt.sv
// 4-bit wrapping counter with enable, synchronous clear and a runtime maximum.
module l17_wrap_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] max,
    output logic [3:0] cnt,
    output logic       at_max
);

    assign at_max = (cnt == max);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 4'd0;
        end else if (en) begin
            cnt <= at_max ? 4'd0 : cnt + 4'd1;
        end
    end

endmodule

// File: rtl/l17_loop_sched.sv
// Three-level loop scheduler (l innermost, then z, then o) with valid/ready beats.
// Optional stall counter output is enabled by defining L17_SCHED_PERF_EN.
module l17_loop_sched
    import l17_pkg::*;
#(
    parameter int L_LEN   = 9,
    parameter int OUT_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic        abort,
    input  logic        pe_ready,
    output logic        beat_valid,
    output logic [3:0]  l_idx,
    output logic [3:0]  z,
    output logic [3:0]  o_idx,
    output logic        l_zero,
    output logic        z_zero,
    output logic        last,
    output logic        u_1_2,
    output logic        busy,
    output logic        done,
`ifdef L17_SCHED_PERF_EN
    output logic [15:0] stall_cnt,
`endif
    output state_e      state_dbg
);

    // Handshake: a beat is consumed on a rising edge where beat_valid and pe_ready
    // are both high and abort is low; otherwise every index and flag holds.

    localparam logic [3:0] L_MAX   = 4'(L_LEN - 1);
    localparam logic [4:0] O_LIMIT = 5'(OUT_LEN);

    state_e     state;
    logic [2:0] mode_q;
    logic [2:0] mode_in;
    logic       start_acc;
    logic       abort_run;
    logic       consume;
    logic       idx_clr;
    logic       l_wrap;
    logic       z_wrap;
    logic [4:0] o_step;
    logic [4:0] o_next;

    assign mode_in   = mode_norm(mode);
    assign start_acc = (state == ST_IDLE) && start;
    assign abort_run = (state == ST_RUN) && abort;
    assign consume   = beat_valid && pe_ready && !abort_run;
    assign idx_clr   = start_acc || abort_run;

    l17_wrap_cnt u_l_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (idx_clr),
        .en     (consume),
        .max    (L_MAX),
        .cnt    (l_idx),
        .at_max (l_wrap)
    );

    l17_wrap_cnt u_z_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (idx_clr),
        .en     (consume && l_zero),
        .max    (zlim_max(mode_q)),
        .cnt    (z),
        .at_max (z_wrap)
    );

    // Modes 3/4 walk o_idx in strides of two; the pass ends once the next step overshoots.
    assign o_step = ((mode_q == MODE_3) || (mode_q == MODE_4)) ? 5'd2 : 5'd1;
    assign o_next = {1'b0, o_idx} + o_step;

    assign l_zero = beat_valid && l_wrap;
    assign z_zero = l_zero && z_wrap;
    assign last   = z_zero && (o_next >= O_LIMIT);

    always_comb begin
        u_1_2 = 1'b0;
        if (mode_q == MODE_1) begin
            u_1_2 = !z_zero;
        end else if (mode_q == MODE_0) begin
            u_1_2 = z_zero;
        end
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_0;
            o_idx      <= 4'd0;
            beat_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        mode_q     <= mode_in;
                        o_idx      <= (mode_in == MODE_4) ? 4'd1 : 4'd0;
                        beat_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort || (consume && last)) begin
                        state      <= ST_DONE;
                        o_idx      <= 4'd0;
                        beat_valid <= 1'b0;
                        done       <= 1'b1;
                    end else if (consume && z_zero) begin
                        o_idx <= o_next[3:0];
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    beat_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

`ifdef L17_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            stall_cnt <= 16'd0;
        end else if ((state == ST_RUN) && !pe_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l17_loop_sched.sv
// Bench for l17_loop_sched: random ready/mode stimulus against a nested-loop beat model.
module tb_l17_loop_sched;
    import l17_pkg::*;

    localparam int L_LEN   = 9;
    localparam int OUT_LEN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  mode;
    logic        abort;
    logic        pe_ready;
    logic        beat_valid;
    logic [3:0]  l_idx;
    logic [3:0]  z;
    logic [3:0]  o_idx;
    logic        l_zero;
    logic        z_zero;
    logic        last;
    logic        u_1_2;
    logic        busy;
    logic        done;
`ifdef L17_SCHED_PERF_EN
    logic [15:0] stall_cnt;
`endif
    state_e      state_dbg;

    int total_cnt = 0;
    int pass_cnt  = 0;
    logic [15:0] exp_q[$];

    l17_loop_sched #(.L_LEN(L_LEN), .OUT_LEN(OUT_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .abort      (abort),
        .pe_ready   (pe_ready),
        .beat_valid (beat_valid),
        .l_idx      (l_idx),
        .z          (z),
        .o_idx      (o_idx),
        .l_zero     (l_zero),
        .z_zero     (z_zero),
        .last       (last),
        .u_1_2      (u_1_2),
        .busy       (busy),
        .done       (done),
`ifdef L17_SCHED_PERF_EN
        .stall_cnt  (stall_cnt),
`endif
        .state_dbg  (state_dbg)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] obs_beat();
        return {o_idx, z, l_idx, l_zero, z_zero, last, u_1_2};
    endfunction

    // Reference model: the pass as a plain list of beats in loop order.
    task automatic build_model(input int m);
        int mm, zl, o0, st;
        logic [15:0] t;
        logic lz, zz, u;
        mm = (m > 4) ? 0 : m;
        zl = (mm == 0) ? 16 : (mm == 2) ? 4 : 8;
        o0 = (mm == 4) ? 1 : 0;
        st = (mm == 3 || mm == 4) ? 2 : 1;
        exp_q.delete();
        for (int o = o0; o < OUT_LEN; o += st)
            for (int zi = 0; zi < zl; zi++)
                for (int l = 0; l < L_LEN; l++) begin
                    lz = (l == L_LEN - 1);
                    zz = lz && (zi == zl - 1);
                    u  = (mm == 1) ? !zz : (mm == 0) ? zz : 1'b0;
                    exp_q.push_back({4'(o), 4'(zi), 4'(l), lz, zz, 1'b0, u});
                end
        t = exp_q.pop_back();
        t[1] = 1'b1;
        exp_q.push_back(t);
    endtask

    // Driver: called at a negedge in IDLE; returns at a negedge in IDLE.
    // rdy_pat: 0 always ready, 1 alternating, 2 random (with stray starts).
    task automatic run_pass(input int m, input int rdy_pat, input int abort_at, input int rst_at);
        int beats, lows, n_exp;
        bit fin;
        logic [15:0] e;
        beats = 0;
        lows  = 0;
        fin   = 0;
        build_model(m);
        n_exp = exp_q.size();
        chk("idle_busy", busy, 0);
        start = 1'b1;
        mode  = 3'(m);
        @(negedge clk);
        start = 1'b0;
        mode  = 3'($urandom_range(0, 7));
        chk("first_valid", beat_valid, 1);
        chk("busy_run", busy, 1);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (!beat_valid) begin
                chk("unexpected_end", beat_valid, 1);
                fin = 1;
            end else begin
                case (rdy_pat)
                    0: pe_ready = 1'b1;
                    1: pe_ready = (cyc % 2 == 0);
                    default: begin
                        pe_ready = 1'($urandom_range(0, 1));
                        start    = 1'($urandom_range(0, 1));
                    end
                endcase
                if (beats == abort_at) begin
                    abort    = 1'b1;
                    pe_ready = 1'b1;
                    start    = 1'b0;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_done", done, 1);
                    chk("abort_valid", beat_valid, 0);
                    chk("abort_idx", {o_idx, z, l_idx}, 0);
                    @(negedge clk);
                    chk("abort_idle", {busy, done}, 0);
                    fin = 1;
                end else if (beats == rst_at) begin
                    rst   = 1'b1;
                    start = 1'b1;
                    @(negedge clk);
                    chk("rst_outs", {beat_valid, busy, done, o_idx, z, l_idx}, 0);
                    @(negedge clk);
                    rst   = 1'b0;
                    start = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        chk("rst_no_done", {done, busy}, 0);
                    end
                    fin = 1;
                end else if (exp_q.size() == 0) begin
                    chk("model_empty", exp_q.size(), 1);
                    fin = 1;
                end else if (!pe_ready) begin
                    lows++;
                    chk("hold", obs_beat(), exp_q[0]);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", obs_beat(), e);
                    beats++;
                    if (e[1]) begin
                        @(negedge clk);
                        chk("done_pulse", done, 1);
                        chk("done_valid", beat_valid, 0);
                        chk("done_busy", busy, 1);
                        chk("beat_count", beats, n_exp);
`ifdef L17_SCHED_PERF_EN
                        chk("stall_cnt", stall_cnt, lows);
`endif
                        start = 1'b1;
                        @(negedge clk);
                        start = 1'b0;
                        chk("done_once", done, 0);
                        chk("idle_after", busy, 0);
                        fin = 1;
                    end
                end
            end
        end
        start = 1'b0;
        if (!fin) chk("timeout", 0, 1);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 3'd0;
        abort    = 1'b0;
        pe_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {beat_valid, busy, done, o_idx, z, l_idx}, 0);
        chk("reset_state", state_dbg, ST_IDLE);
        rst = 1'b0;
        @(negedge clk);

        run_pass(2, 0, -1, -1);
        run_pass(1, 0, -1, -1);
        run_pass(0, 2, -1, -1);
        run_pass(3, 1, -1, -1);
        run_pass(4, 2, -1, -1);
        run_pass(6, 0, -1, -1);
        run_pass(0, 0, 20, -1);
        run_pass(1, 2, -1, -1);
        run_pass(2, 2, -1, 50);
        run_pass(2, 0, -1, -1);
        run_pass(3, 2, -1, -1);

        // Final report
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
